// File: rtl/cc_pkg.sv
// Shared types and helpers for the condition-code unit: the {n,z,p} flag
// struct, branch-mask bit positions and the flag derivation function.
package cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  // Widest result the flag helper accepts; callers sign-extend into it.
  localparam int CC_MAX_W = 64;

  localparam int MASK_N = 2;
  localparam int MASK_Z = 1;
  localparam int MASK_P = 0;

  function automatic cc_t cc_flags(input logic [CC_MAX_W-1:0] data,
                                   input logic signed_mode);
    cc_t f;
    f.z = (data == '0);
    f.n = signed_mode & data[CC_MAX_W-1];
    f.p = ~f.n & ~f.z;
    return f;
  endfunction

endpackage

// File: rtl/cc_fifo.sv
// Circular queue of in-flight condition codes with push/pop/clear and
// occupancy count; the head entry is visible combinationally on dout.
module cc_fifo
  import cc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  cc_t                        din,
  output cc_t                        dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  cc_t              mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Clear wins over push/pop so a flush leaves the queue truly empty.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cc_unit.sv
// Condition-code unit: speculative and committed NZP registers, an in-flight
// update queue so a flush can restore architectural flags, and branch bypass.
module cc_unit
  import cc_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         DEPTH    = 4,
  parameter int         SIGNED   = 1,
  parameter logic [2:0] RESET_CC = 3'b000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       cc_we,
  input  logic [DATA_W-1:0]          cc_data,
  output logic                       cc_ready,
  input  logic                       retire,
  input  logic                       flush,
  input  logic                       br_valid,
  input  logic [2:0]                 br_mask,
  output logic                       br_taken,
  output logic                       N,
  output logic                       Z,
  output logic                       P,
  output logic                       cN,
  output logic                       cZ,
  output logic                       cP,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       ovf_err,
  output logic                       udf_err
);

  cc_t                specCc;
  cc_t                commCc;
  cc_t                newCc;
  cc_t                headCc;
  cc_t                effCc;
  cc_t                commNext;
  logic [CC_MAX_W-1:0] dataExt;
  logic               full;
  logic               empty;
  logic               wrAcc;
  logic               rdAcc;

  assign dataExt = CC_MAX_W'($signed(cc_data));
  assign newCc   = cc_flags(dataExt, SIGNED != 0);

  assign cc_ready = ~full;
  assign wrAcc    = cc_we & ~full & ~flush;
  assign rdAcc    = retire & ~empty;

  // The retire is folded in before a flush reloads the speculative flags.
  assign commNext = rdAcc ? headCc : commCc;
  assign effCc    = wrAcc ? newCc : specCc;

  assign br_taken = br_valid & ~flush &
                    ((br_mask[MASK_N] & effCc.n) |
                     (br_mask[MASK_Z] & effCc.z) |
                     (br_mask[MASK_P] & effCc.p));

  assign {N, Z, P}    = specCc;
  assign {cN, cZ, cP} = commCc;

  cc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (wrAcc),
    .pop   (rdAcc),
    .clear (flush),
    .din   (newCc),
    .dout  (headCc),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      specCc  <= cc_t'(RESET_CC);
      commCc  <= cc_t'(RESET_CC);
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      commCc <= commNext;
      if (flush)      specCc <= commNext;
      else if (wrAcc) specCc <= newCc;
      if (cc_we && full && !flush) ovf_err <= 1'b1;
      if (retire && empty)         udf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cc_unit.sv
// Bench for cc_unit: a signed and an unsigned instance share stimulus and are
// compared each cycle against a queue-based model of the flag rules.
module tb_cc_unit;

  logic        Clk      = 1'b0;
  logic        Reset    = 1'b0;
  logic        cc_we    = 1'b0;
  logic [15:0] cc_data  = 16'h0;
  logic        retire   = 1'b0;
  logic        flush    = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_mask  = 3'b0;

  logic       cc_ready, br_taken, N, Z, P, cN, cZ, cP, ovf_err, udf_err;
  logic [2:0] pending;
  logic       uReady, uBr, uN, uZ, uP, ucN, ucZ, ucP, uOvf, uUdf;
  logic [2:0] uPending;

  int vectors = 0;
  int errors  = 0;

  logic [5:0] mq[$];
  logic [5:0] mSpec;
  logic [5:0] mComm;
  logic       mOvf;
  logic       mUdf;

  logic [11:0] stateAct;
  logic [11:0] uStateAct;
  assign stateAct  = {N, Z, P, cN, cZ, cP, pending, cc_ready, ovf_err, udf_err};
  assign uStateAct = {uN, uZ, uP, ucN, ucZ, ucP, uPending, uReady, uOvf, uUdf};

  always #5 Clk = ~Clk;

  cc_unit dut (
    .Clk(Clk), .Reset(Reset), .cc_we(cc_we), .cc_data(cc_data), .cc_ready(cc_ready),
    .retire(retire), .flush(flush), .br_valid(br_valid), .br_mask(br_mask),
    .br_taken(br_taken), .N(N), .Z(Z), .P(P), .cN(cN), .cZ(cZ), .cP(cP),
    .pending(pending), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  cc_unit #(.SIGNED(0)) dutU (
    .Clk(Clk), .Reset(Reset), .cc_we(cc_we), .cc_data(cc_data), .cc_ready(uReady),
    .retire(retire), .flush(flush), .br_valid(br_valid), .br_mask(br_mask),
    .br_taken(uBr), .N(uN), .Z(uZ), .P(uP), .cN(ucN), .cZ(ucZ), .cP(ucP),
    .pending(uPending), .ovf_err(uOvf), .udf_err(uUdf)
  );

  // Upper three bits are the signed-mode flags, lower three the unsigned ones.
  function automatic logic [5:0] flags6(input logic [15:0] d);
    logic z, n;
    z = (d == 16'h0);
    n = d[15];
    return {n, z, !n && !z, 1'b0, z, !z};
  endfunction

  function automatic logic [1:0] brExp();
    logic [5:0] eff;
    eff = (cc_we && mq.size() < 4 && !flush) ? flags6(cc_data) : mSpec;
    return {br_valid && !flush && (|(br_mask & eff[5:3])),
            br_valid && !flush && (|(br_mask & eff[2:0]))};
  endfunction

  function automatic logic [11:0] stateExp();
    return {mSpec[5:3], mComm[5:3], 3'(mq.size()), mq.size() < 4, mOvf, mUdf};
  endfunction

  function automatic logic [11:0] uStateExp();
    return {mSpec[2:0], mComm[2:0], 3'(mq.size()), mq.size() < 4, mOvf, mUdf};
  endfunction

  task automatic modelReset();
    mq.delete();
    mSpec = 6'b0;
    mComm = 6'b0;
    mOvf  = 1'b0;
    mUdf  = 1'b0;
  endtask

  task automatic modelStep();
    logic [5:0] f;
    logic       isFull;
    f      = flags6(cc_data);
    isFull = (mq.size() >= 4);
    if (cc_we && isFull && !flush) mOvf = 1'b1;
    if (retire && mq.size() == 0)  mUdf = 1'b1;
    if (retire && mq.size() != 0)  mComm = mq.pop_front();
    if (flush) begin
      mq.delete();
      mSpec = mComm;
    end else if (cc_we && !isFull) begin
      mq.push_back(f);
      mSpec = f;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] data, input logic ret,
                               input logic fl, input logic bv, input logic [2:0] mask);
    cc_we    = we;
    cc_data  = data;
    retire   = ret;
    flush    = fl;
    br_valid = bv;
    br_mask  = mask;
    #1;
  endtask

  task automatic advance();
    @(posedge Clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'b0);
    Reset = 1'b1;
    #1;
    modelReset();
    vectors++;
    if (stateAct !== stateExp()) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b, expected %b", stateAct, stateExp());
    end
    vectors++;
    if ({N, Z, P, cN, cZ, cP, pending, cc_ready} !== 10'b000_000_000_1) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b, expected %b",
               {N, Z, P, cN, cZ, cP, pending, cc_ready}, 10'b000_000_000_1);
    end
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_signed_write();
    test_reset();
    applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3'b0);
    advance();
    vectors++;
    if ({N, Z, P, cN, cZ, cP, pending} !== 9'b100_000_001) begin
      errors++;
      $display("[TB] FAIL signed_write: got %b, expected %b", {N, Z, P, cN, cZ, cP, pending}, 9'b100_000_001);
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'b0);
    advance();
    vectors++;
    if ({cN, cZ, cP, pending} !== 6'b100_000) begin
      errors++;
      $display("[TB] FAIL signed_retire: got %b, expected %b", {cN, cZ, cP, pending}, 6'b100_000);
    end
  endtask

  task automatic test_unsigned();
    test_reset();
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'b0);
    advance();
    vectors++;
    if ({uN, uZ, uP, N, Z, P} !== 6'b001_100) begin
      errors++;
      $display("[TB] FAIL unsigned_ffff: got %b, expected %b", {uN, uZ, uP, N, Z, P}, 6'b001_100);
    end
    applyStimulus(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 3'b0);
    advance();
    vectors++;
    if ({uN, uZ, uP} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL unsigned_zero: got %b, expected %b", {uN, uZ, uP}, 3'b010);
    end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] vals[5];
    logic [2:0]  commExp[4];
    vals    = '{16'd7, 16'd0, 16'd1, 16'd2, 16'd3};
    commExp = '{3'b001, 3'b010, 3'b001, 3'b001};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vals[i], 1'b0, 1'b0, 1'b0, 3'b0);
      advance();
      if (i == 3) begin
        vectors++;
        if ({cc_ready, pending, ovf_err} !== 5'b0_100_0) begin
          errors++;
          $display("[TB] FAIL fill_full: got %b, expected %b", {cc_ready, pending, ovf_err}, 5'b0_100_0);
        end
      end
    end
    vectors++;
    if ({ovf_err, pending, N, Z, P} !== 7'b1_100_001) begin
      errors++;
      $display("[TB] FAIL fill_overflow: got %b, expected %b", {ovf_err, pending, N, Z, P}, 7'b1_100_001);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'b0);
      advance();
      vectors++;
      if ({cN, cZ, cP} !== commExp[i]) begin
        errors++;
        $display("[TB] FAIL drain_commit%0d: got %b, expected %b", i, {cN, cZ, cP}, commExp[i]);
      end
    end
    vectors++;
    if (stateAct !== stateExp() || pending !== 3'd0) begin
      errors++;
      $display("[TB] FAIL drain_state: got %b, expected %b", stateAct, stateExp());
    end
  endtask

  task automatic test_flush();
    test_reset();
    applyStimulus(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 3'b0);
    advance();
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'b0);
    advance();
    applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3'b0);
    advance();
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 3'b0);
    advance();
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 3'b0);
    advance();
    vectors++;
    if ({cN, cZ, cP, N, Z, P, pending, ovf_err} !== 10'b100_100_000_0) begin
      errors++;
      $display("[TB] FAIL flush_restore: got %b, expected %b",
               {cN, cZ, cP, N, Z, P, pending, ovf_err}, 10'b100_100_000_0);
    end
  endtask

  task automatic test_bypass();
    test_reset();
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 3'b0);
    advance();
    applyStimulus(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 3'b010);
    vectors++;
    if (br_taken !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bypass_taken: got %b, expected %b", br_taken, 1'b1);
    end
    applyStimulus(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 3'b010);
    vectors++;
    if (br_taken !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_flush: got %b, expected %b", br_taken, 1'b0);
    end
    advance();
    vectors++;
    if (stateAct !== stateExp()) begin
      errors++;
      $display("[TB] FAIL bypass_state: got %b, expected %b", stateAct, stateExp());
    end
  endtask

  task automatic test_underflow();
    test_reset();
    applyStimulus(1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 3'b0);
    advance();
    vectors++;
    if ({udf_err, cN, cZ, cP, pending, N, Z, P} !== 10'b1_000_001_001) begin
      errors++;
      $display("[TB] FAIL underflow: got %b, expected %b",
               {udf_err, cN, cZ, cP, pending, N, Z, P}, 10'b1_000_001_001);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        Reset = 1'b1;
        #1;
        modelReset();
        vectors++;
        if (stateAct !== stateExp()) begin
          errors++;
          $display("[TB] FAIL rand_reset%0d: got %b, expected %b", i, stateAct, stateExp());
        end
        Reset = 1'b0;
      end
      case ($urandom_range(3))
        0:       d = 16'h0;
        1:       d = 16'h8000 | 16'($urandom);
        default: d = 16'($urandom);
      endcase
      applyStimulus($urandom_range(9) < 6, d, $urandom_range(9) < 4,
                    $urandom_range(19) == 0, $urandom_range(1) == 1, 3'($urandom));
      vectors++;
      if ({br_taken, uBr} !== brExp()) begin
        errors++;
        $display("[TB] FAIL rand_branch%0d: got %b, expected %b", i, {br_taken, uBr}, brExp());
      end
      advance();
      vectors++;
      if (stateAct !== stateExp()) begin
        errors++;
        $display("[TB] FAIL rand_state%0d: got %b, expected %b", i, stateAct, stateExp());
      end
      vectors++;
      if (uStateAct !== uStateExp()) begin
        errors++;
        $display("[TB] FAIL rand_ustate%0d: got %b, expected %b", i, uStateAct, uStateExp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_write();
    test_unsigned();
    test_fill_overflow();
    test_flush();
    test_bypass();
    test_underflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
